lsu_initiator: RTL and testbench
================================

LSU_INITIATOR -- requirements
Module: lsu_initiator

Interface
REQ-001 Parameter MAX_WAIT, default 16: maximum number of cycles the block waits for mem_ready before it aborts a transaction.
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  CPU access request; sampled only in IDLE.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_size  input  2  access size: 00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-007 req_signed  input  1  load extension: 1 = sign-extend, 0 = zero-extend; ignored for word accesses and stores.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned (byte in bits [7:0], halfword in [15:0]).
REQ-010 busy  output  1  stall to the pipeline; high in every state except IDLE.
REQ-011 mem_valid  output  1  memory request strobe.
REQ-012 mem_we  output  1  memory write enable.
REQ-013 mem_addr  output  32  word-aligned address; bits [1:0] always 00.
REQ-014 mem_be  output  4  byte enables; bit i selects byte lane [8i+7:8i].
REQ-015 mem_wdata  output  32  store data replicated into the addressed lane(s).
REQ-016 mem_ready  input  1  responder accepts or completes the request in the cycle it is sampled high.
REQ-017 mem_rdata  input  32  read word; valid in the mem_ready cycle.
REQ-018 resp_valid  output  1  one-cycle completion pulse.
REQ-019 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-020 resp_err  output  2  00 ok, 01 misaligned or illegal size, 10 timeout.

Function
REQ-021 The block SHALL implement the FSM IDLE -> ACCESS -> RESP -> IDLE, plus IDLE -> RESP directly for misaligned or illegal requests.
REQ-022 IDLE: req_valid=1 SHALL latch all req_* inputs; illegal size or misalignment (half with addr[0]=1, word with addr[1:0]!=0) SHALL go to RESP with err=01 and SHALL NOT assert mem_valid.
REQ-023 ACCESS: mem_valid SHALL be 1, with mem_addr, mem_we, mem_be and mem_wdata held constant from the latched request until mem_ready=1.
REQ-024 Byte enables SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads SHALL drive the same mask.
REQ-025 mem_wdata SHALL be: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-026 When mem_ready=1 in ACCESS, the block SHALL capture mem_rdata, select the addressed lane, extend it per size/signed, and go to RESP.
REQ-027 Wait counter: cleared on entry to ACCESS, incremented each ACCESS cycle with mem_ready=0; reaching MAX_WAIT SHALL force RESP with err=10 and resp_rdata=0.
REQ-028 mem_ready arriving in the same cycle the counter reaches MAX_WAIT SHALL count as success (err=00).
REQ-029 RESP SHALL last exactly one cycle: resp_valid=1 with rdata/err, then IDLE.
REQ-030 Latency: a request accepted in cycle N with mem_ready=1 in cycle N+1 SHALL give resp_valid in N+2; a misaligned request SHALL give resp_valid in N+1.
REQ-031 busy SHALL be combinational from state, so a new request is accepted in the first IDLE cycle after RESP.
REQ-032 mem_ready or mem_rdata outside ACCESS SHALL be ignored.
REQ-033 Outside ACCESS: mem_valid=0, mem_we=0, mem_be=0. Outside RESP: resp_valid=0, resp_rdata=0, resp_err=00.

Reset
REQ-034 reset=1 at a clock edge SHALL force IDLE, clear the counter and all latched request fields, and give every output 0 in the following cycle.
REQ-035 Reset during ACCESS or RESP SHALL abort the transaction without a resp_valid pulse; reset has priority over mem_ready.

Verification
REQ-036 Byte store: we=1, size=00, addr=0x0000_0006, wdata=0x1234_56AB, mem_ready=1 -> mem_addr=0x4, mem_be=0100, mem_wdata=0xABAB_ABAB; resp_valid two cycles after accept, err=00.
REQ-037 Signed half load: addr=0x0000_0002, signed=1, mem_rdata=0x8001_7FFF -> resp_rdata=0xFFFF_8001; with signed=0 -> 0x0000_8001.
REQ-038 Misaligned word: addr=0x0000_0001, size=10 -> no mem_valid ever; resp_valid next cycle with err=01 and rdata=0.
REQ-039 Timeout: mem_ready held 0 -> mem_valid held for exactly 16 cycles, then resp_valid with err=10; a mem_ready arriving in the 16th cycle instead gives err=00.
REQ-040 Reset in the 3rd ACCESS cycle -> next cycle busy=0, mem_valid=0, no resp_valid; a subsequent word load at 0x8 completes normally.
REQ-041 Back-to-back: second req_valid held high through RESP -> accepted in the first IDLE cycle, mem_valid in the cycle after.

Source files
------------

// File: rtl/lsu_if.sv
// Bundle of CPU request, memory bus and response signals for the load/store initiator.
// master is the initiator's view; slave is the view of the surrounding CPU and memory.
interface lsu_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        busy;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  mem_ready, mem_rdata,
    output busy, mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output resp_valid, resp_rdata, resp_err
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output mem_ready, mem_rdata,
    input  busy, mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_initiator.sv
// Load/store initiator: turns one CPU byte/half/word access into a single word-bus
// transaction with lane steering, load extension, alignment checks and a wait timeout.
module lsu_initiator #(
  parameter int MAX_WAIT = 16
) (
  input logic   clk,
  input logic   reset,
  lsu_if.master bus
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic        latch;
  logic        we_q, signed_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_nxt;
  logic [1:0]  err_q, err_nxt;
  logic        in_access, in_resp;

  function automatic logic bad_req(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lane[0];
      2'b10:   return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 4'b0001 << lane;
      2'b01:   return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic sgn);
    logic [15:0]        low;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    low = 16'(word >> {lane, 3'b000});
    b   = low[7:0];
    h   = low;
    case (size)
      2'b00:   if (sgn) ext = b; else ext = $signed({24'd0, low[7:0]});
      2'b01:   if (sgn) ext = h; else ext = $signed({16'd0, low});
      default: ext = $signed(word);
    endcase
    return $unsigned(ext);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= ERR_OK;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rdata_q <= rdata_nxt;
      err_q   <= err_nxt;
      if (latch) begin
        we_q     <= bus.req_we;
        signed_q <= bus.req_signed;
        size_q   <= bus.req_size;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rdata_nxt = rdata_q;
    err_nxt   = err_q;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          latch     = 1'b1;
          rdata_nxt = '0;
          cnt_nxt   = '0;
          if (bad_req(bus.req_size, bus.req_addr[1:0])) begin
            state_nxt = RESP;
            err_nxt   = ERR_ALIGN;
          end else begin
            state_nxt = ACCESS;
            err_nxt   = ERR_OK;
          end
        end
      end
      ACCESS: begin
        // A ready in the final allowed cycle wins over the timeout.
        if (bus.mem_ready) begin
          state_nxt = RESP;
          err_nxt   = ERR_OK;
          rdata_nxt = we_q ? 32'd0 : load_extend(bus.mem_rdata, size_q, addr_q[1:0], signed_q);
        end else if (cnt == CNT_W'(MAX_WAIT - 1)) begin
          state_nxt = RESP;
          err_nxt   = ERR_TMO;
          rdata_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_access = (state == ACCESS);
  assign in_resp   = (state == RESP);

  assign bus.busy       = (state != IDLE);
  assign bus.mem_valid  = in_access;
  assign bus.mem_we     = in_access & we_q;
  assign bus.mem_addr   = in_access ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus.mem_be     = in_access ? lane_mask(size_q, addr_q[1:0]) : 4'b0000;
  assign bus.mem_wdata  = in_access ? lane_data(size_q, wdata_q) : 32'd0;
  assign bus.resp_valid = in_resp;
  assign bus.resp_rdata = in_resp ? rdata_q : 32'd0;
  assign bus.resp_err   = in_resp ? err_q : ERR_OK;

endmodule

// File: tb/tb_lsu_initiator.sv
// Randomized bench for lsu_initiator with a transaction-level reference model.
module tb_lsu_initiator;
  localparam int MAX_WAIT = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  lsu_if bus();

  lsu_initiator #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_illegal(input logic [1:0] size, input logic [31:0] addr);
    int a = int'(addr % 4);
    if (size == 2'd3) return 1;
    if (size == 2'd1 && (a % 2) != 0) return 1;
    if (size == 2'd2 && a != 0) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    int a = int'(addr % 4);
    if (size == 2'd0) return 4'(1 << a);
    if (size == 2'd1) return 4'(3 << a);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_rdata(input logic we, input logic [1:0] size, input logic sgn,
                                          input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    if (we) return 32'd0;
    if (size == 2'd2) return rd;
    v = rd / (32'd1 << (8 * (addr % 4)));
    if (size == 2'd0) begin
      v = v % 256;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else begin
      v = v % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  // delay = ACCESS cycles before mem_ready; delay >= MAX_WAIT means it never comes.
  task automatic do_txn(input string name, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int delay);
    int          cyc;
    int          exp_cyc;
    logic [1:0]  exp_err;
    logic [31:0] exp_rd;
    logic [71:0] got_v, exp_v;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.mem_ready  = 1'($urandom);
    bus.mem_rdata  = $urandom;
    step;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_size   = 2'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    if (m_illegal(size, addr)) begin
      checks++;
      if ({bus.mem_valid, bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.busy} !==
          {1'b0, 1'b1, 2'b01, 32'd0, 1'b1}) begin
        errors++;
        $display("FAIL %s illegal-resp: got mv=%b rv=%b err=%b rd=%h busy=%b want mv=0 rv=1 err=01 rd=0 busy=1",
                 name, bus.mem_valid, bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.busy);
      end
    end else begin
      exp_cyc = (delay < MAX_WAIT) ? delay + 1 : MAX_WAIT;
      exp_err = (delay < MAX_WAIT) ? 2'b00 : 2'b10;
      exp_rd  = (delay < MAX_WAIT) ? m_rdata(we, size, sgn, addr, rdata) : 32'd0;
      cyc = 0;
      while (bus.mem_valid === 1'b1 && cyc < 40) begin
        cyc++;
        checks++;
        got_v = {bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_be,
                 bus.mem_wdata & {32{we}}, bus.busy, bus.resp_valid};
        exp_v = {1'b1, we, addr & 32'hFFFF_FFFC, m_be(size, addr),
                 m_wdata(size, wdata) & {32{we}}, 1'b1, 1'b0};
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL %s access-cyc%0d: got we=%b addr=%h be=%b wd=%h want we=%b addr=%h be=%b wd=%h",
                   name, cyc, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
                   we, addr & 32'hFFFF_FFFC, m_be(size, addr), m_wdata(size, wdata));
        end
        bus.mem_ready = (cyc == delay + 1);
        bus.mem_rdata = (cyc == delay + 1) ? rdata : $urandom;
        step;
      end
      bus.mem_ready = 1'($urandom);
      bus.mem_rdata = $urandom;
      checks++;
      if (cyc !== exp_cyc) begin
        errors++;
        $display("FAIL %s mem_valid-cycles: got %0d want %0d", name, cyc, exp_cyc);
      end
      checks++;
      if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {1'b1, exp_err, exp_rd}) begin
        errors++;
        $display("FAIL %s resp: got rv=%b err=%b rd=%h want rv=1 err=%b rd=%h",
                 name, bus.resp_valid, bus.resp_err, bus.resp_rdata, exp_err, exp_rd);
      end
    end
    step;
    bus.mem_ready = 1'b0;
    checks++;
    if ({bus.resp_valid, bus.busy, bus.mem_valid, bus.resp_err, bus.resp_rdata} !== 36'd0) begin
      errors++;
      $display("FAIL %s back-to-idle: got rv=%b busy=%b mv=%b err=%b rd=%h want all 0",
               name, bus.resp_valid, bus.busy, bus.mem_valid, bus.resp_err, bus.resp_rdata);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_signed = 1'b0;
    bus.req_addr = 32'h40; bus.req_wdata = 32'hDEAD_BEEF;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    step;
    step;
    checks++;
    if ({bus.busy, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
         bus.resp_valid, bus.resp_rdata, bus.resp_err} !== 105'd0) begin
      errors++;
      $display("FAIL reset-outputs: got busy=%b mv=%b addr=%h be=%b wd=%h rv=%b want all 0",
               bus.busy, bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.resp_valid);
    end
    reset = 1'b0;
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b0;
    step;
    checks++;
    if ({bus.busy, bus.mem_valid, bus.resp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset-release-idle: got busy=%b mv=%b rv=%b want 000",
               bus.busy, bus.mem_valid, bus.resp_valid);
    end
  endtask

  task automatic test_directed;
    do_txn("byte-store", 1'b1, 2'b00, 1'b0, 32'h0000_0006, 32'h1234_56AB, 32'h0, 0);
    do_txn("half-load-signed", 1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0);
    do_txn("half-load-unsigned", 1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 32'h8001_7FFF, 0);
    do_txn("misaligned-word", 1'b0, 2'b10, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 0);
    do_txn("illegal-size", 1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'h55, 32'h0, 0);
    do_txn("byte-load-signed", 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h9A00_0000, 2);
  endtask

  task automatic test_timeout;
    do_txn("timeout", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, MAX_WAIT);
    do_txn("ready-last-cycle", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, MAX_WAIT - 1);
    do_txn("timeout-store", 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'hCAFE_F00D, 32'h0, MAX_WAIT + 3);
  endtask

  task automatic test_reset_abort;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_signed = 1'b0;
    bus.req_addr = 32'h0000_0010; bus.req_wdata = 32'h0;
    bus.mem_ready = 1'b0;
    step;
    bus.req_valid = 1'b0;
    step;
    step;
    checks++;
    if (bus.mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort-in-access: got mv=%b want 1", bus.mem_valid);
    end
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hAAAA_5555;
    step;
    checks++;
    if ({bus.busy, bus.mem_valid, bus.resp_valid, bus.resp_rdata, bus.resp_err} !== 37'd0) begin
      errors++;
      $display("FAIL abort-after-reset: got busy=%b mv=%b rv=%b rd=%h err=%b want all 0",
               bus.busy, bus.mem_valid, bus.resp_valid, bus.resp_rdata, bus.resp_err);
    end
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    step;
    checks++;
    if ({bus.busy, bus.resp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL abort-no-resp: got busy=%b rv=%b want 00", bus.busy, bus.resp_valid);
    end
    do_txn("load-after-abort", 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 32'h0BAD_CAFE, 1);
  endtask

  task automatic test_back_to_back;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10; bus.req_signed = 1'b0;
    bus.req_addr = 32'h0000_0100; bus.req_wdata = 32'h1111_2222;
    step;
    bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b1;
    bus.req_addr = 32'h0000_0205; bus.req_wdata = 32'h0;
    bus.mem_ready = 1'b1;
    step;
    bus.mem_ready = 1'b0;
    checks++;
    if (bus.resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b-first-resp: got rv=%b want 1", bus.resp_valid);
    end
    step;
    checks++;
    if ({bus.busy, bus.mem_valid, bus.resp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL b2b-idle-gap: got busy=%b mv=%b rv=%b want 000",
               bus.busy, bus.mem_valid, bus.resp_valid);
    end
    step;
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.mem_valid, bus.mem_addr, bus.mem_be} !== {1'b1, 32'h0000_0204, 4'b0010}) begin
      errors++;
      $display("FAIL b2b-second-access: got mv=%b addr=%h be=%b want mv=1 addr=00000204 be=0010",
               bus.mem_valid, bus.mem_addr, bus.mem_be);
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0000_F000;
    step;
    bus.mem_ready = 1'b0;
    checks++;
    if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {1'b1, 2'b00, 32'hFFFF_FFF0}) begin
      errors++;
      $display("FAIL b2b-second-resp: got rv=%b err=%b rd=%h want rv=1 err=00 rd=fffffff0",
               bus.resp_valid, bus.resp_err, bus.resp_rdata);
    end
    step;
  endtask

  task automatic test_random;
    logic [1:0]  size;
    logic [31:0] addr;
    int          delay;
    for (int i = 0; i < 30; i++) begin
      size = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        if (size == 2'd1) addr[0] = 1'b0;
        if (size == 2'd2) addr[1:0] = 2'b00;
      end
      delay = ($urandom_range(0, 9) < 6) ? $urandom_range(0, 3) : $urandom_range(0, MAX_WAIT + 4);
      do_txn($sformatf("rand%0d", i), 1'($urandom), size, 1'($urandom), addr,
             $urandom, $urandom, delay);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        bus.mem_ready = 1'($urandom);
        step;
      end
      bus.mem_ready = 1'b0;
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    reset = 1'b1;
    test_reset;
    test_directed;
    test_timeout;
    test_reset_abort;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
